// File: rtl/apb2wbn_pkg.sv
// Shared types and helpers for the APB-to-Wishbone bridge.
package apb2wbn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WBN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Retry counter width; kept at least one bit so RTY_MAX=0 still elaborates.
  function automatic int unsigned rty_cnt_w(input int unsigned rty_max);
    return (rty_max == 0) ? 1 : $clog2(rty_max + 1);
  endfunction

endpackage

// File: rtl/apb2wbn.sv
// APB slave to Wishbone 3 master bridge, one outstanding transfer, registered outputs.
// Optional Wishbone retry handling is enabled with `define APB2WBN_RETRY_EN.
module apb2wbn
  import apb2wbn_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned SW      = DW / 8,
  parameter int unsigned RTY_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          apb_psel,
  input  logic          apb_penable,
  input  logic          apb_pwrite,
  input  logic [AW-1:0] apb_paddr,
  input  logic [SW-1:0] apb_pstrb,
  input  logic [DW-1:0] apb_pwdata,
  output logic [DW-1:0] apb_prdata,
  output logic          apb_pready,
  output logic          apb_pslverr,
  output logic          wbn_cyc,
  output logic          wbn_stb,
  output logic          wbn_we,
  output logic [AW-1:0] wbn_adr,
  output logic [SW-1:0] wbn_sel,
  output logic [DW-1:0] wbn_dat_w,
  input  logic [DW-1:0] wbn_dat_r,
  input  logic          wbn_ack,
  input  logic          wbn_err,
  input  logic          wbn_rty
);

  state_e        state_q;
  logic          cyc_q, stb_q, we_q, pready_q, pslverr_q;
  logic [AW-1:0] adr_q;
  logic [SW-1:0] sel_q;
  logic [DW-1:0] dat_w_q, prdata_q;
  logic          rty_fatal;

`ifdef APB2WBN_RETRY_EN
  localparam int unsigned CW = rty_cnt_w(RTY_MAX);
  logic [CW-1:0] cnt_q;

  // A retry is fatal only once every permitted reissue has been spent.
  assign rty_fatal = wbn_rty && (cnt_q == CW'(RTY_MAX));
`else
  // RTY_MAX only matters when retries are enabled.
  if (RTY_MAX > 0) begin : g_rty_unused
  end
  assign rty_fatal = wbn_rty;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_w_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB2WBN_RETRY_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (apb_psel && !apb_penable) begin
            state_q  <= WBN;
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            we_q     <= apb_pwrite;
            adr_q    <= apb_paddr;
            sel_q    <= apb_pwrite ? apb_pstrb : {SW{1'b1}};
            dat_w_q  <= apb_pwdata;
            prdata_q <= '0;
          end
        end
        WBN: begin
          if (wbn_ack || wbn_err || wbn_rty) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
          end
          // Termination priority: err, then retry, then ack.
          if (wbn_err || rty_fatal) begin
            state_q   <= DONE;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= '0;
`ifdef APB2WBN_RETRY_EN
          end else if (wbn_rty) begin
            state_q <= GAP;
            cnt_q   <= cnt_q + CW'(1);
`endif
          end else if (wbn_ack) begin
            state_q  <= DONE;
            pready_q <= 1'b1;
            prdata_q <= we_q ? DW'(0) : wbn_dat_r;
          end
        end
`ifdef APB2WBN_RETRY_EN
        GAP: begin
          state_q <= WBN;
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
        end
`endif
        DONE: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
`ifdef APB2WBN_RETRY_EN
          cnt_q     <= '0;
`endif
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wbn_cyc     = cyc_q;
  assign wbn_stb     = stb_q;
  assign wbn_we      = we_q;
  assign wbn_adr     = adr_q;
  assign wbn_sel     = sel_q;
  assign wbn_dat_w   = dat_w_q;
  assign apb_prdata  = prdata_q;
  assign apb_pready  = pready_q;
  assign apb_pslverr = pslverr_q;

endmodule

// File: tb/tb_apb2wbn.sv
// Self-checking bench for apb2wbn: APB master tasks, a configurable Wishbone slave and a reference model.
module tb_apb2wbn;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned SW      = 4;
  localparam int unsigned RTY_MAX = 3;
  localparam int          BUDGET  = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          apb_psel = 1'b0, apb_penable = 1'b0, apb_pwrite = 1'b0;
  logic [AW-1:0] apb_paddr = '0;
  logic [SW-1:0] apb_pstrb = '0;
  logic [DW-1:0] apb_pwdata = '0;
  logic [DW-1:0] apb_prdata;
  logic          apb_pready, apb_pslverr;
  logic          wbn_cyc, wbn_stb, wbn_we;
  logic [AW-1:0] wbn_adr;
  logic [SW-1:0] wbn_sel;
  logic [DW-1:0] wbn_dat_w, wbn_dat_r;
  logic          wbn_ack, wbn_err, wbn_rty;

  int n_checks = 0;
  int n_pass   = 0;

  apb2wbn #(.AW(AW), .DW(DW), .SW(SW), .RTY_MAX(RTY_MAX)) dut (
    .clk(clk), .rst(rst),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pstrb(apb_pstrb), .apb_pwdata(apb_pwdata),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .wbn_cyc(wbn_cyc), .wbn_stb(wbn_stb), .wbn_we(wbn_we), .wbn_adr(wbn_adr),
    .wbn_sel(wbn_sel), .wbn_dat_w(wbn_dat_w), .wbn_dat_r(wbn_dat_r),
    .wbn_ack(wbn_ack), .wbn_err(wbn_err), .wbn_rty(wbn_rty)
  );

  always #5 clk = ~clk;

  // Wishbone slave: cfg_nrty retries first, then the final response flags, each after cfg_wait wait states.
  int          cfg_wait = 0, cfg_nrty = 0;
  logic        f_ack = 1'b1, f_err = 1'b0, f_rty = 1'b0;
  logic [31:0] cfg_rdata = '0;
  int          wcnt = 0, attempt = 0;
  logic        live, fin;

  always_comb begin
    live      = wbn_cyc && wbn_stb && (wcnt == cfg_wait);
    fin       = attempt >= cfg_nrty;
    wbn_ack   = live && fin && f_ack;
    wbn_err   = live && fin && f_err;
    wbn_rty   = live && (!fin || f_rty);
    wbn_dat_r = cfg_rdata;
  end

  always @(posedge clk) begin
    if (apb_psel && !apb_penable && !wbn_cyc) begin
      wcnt    <= 0;
      attempt <= 0;
    end else if (wbn_cyc && wbn_stb) begin
      if (live) begin
        wcnt    <= 0;
        attempt <= attempt + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // Bus monitor sampled on the falling edge.
  int          stb_cyc, bursts, pready_cnt;
  logic        prev_stb, changed;
  logic [31:0] adr_seen, dat_seen;
  logic [3:0]  sel_seen;
  logic        we_seen;

  task automatic clear_mon();
    stb_cyc = 0; bursts = 0; pready_cnt = 0; changed = 1'b0;
    adr_seen = '0; dat_seen = '0; sel_seen = '0; we_seen = 1'b0;
  endtask

  initial begin
    prev_stb = 1'b0;
    clear_mon();
  end

  always @(negedge clk) begin
    if (wbn_stb) begin
      if (!prev_stb) bursts++;
      if (stb_cyc == 0) begin
        adr_seen = wbn_adr; dat_seen = wbn_dat_w; sel_seen = wbn_sel; we_seen = wbn_we;
      end else if (wbn_adr !== adr_seen || wbn_dat_w !== dat_seen ||
                   wbn_sel !== sel_seen || wbn_we !== we_seen || !wbn_cyc) begin
        changed = 1'b1;
      end
      stb_cyc++;
    end
    if (apb_pready) pready_cnt++;
    prev_stb = wbn_stb;
  end

  // Reference model: walks the attempts the slave will present and applies err > rty > ack.
  function automatic void model(input logic we, input int wt, input int nrty,
                                input logic fa, input logic fe, input logic fr,
                                input logic [31:0] rd, output int lat, output int nb,
                                output logic err, output logic [31:0] prd);
    int   a;
    bit   done;
    logic ra, re, rr;
    a = 0; done = 0; lat = 1; nb = 0; err = 1'b0; prd = '0;
    while (!done) begin
      nb++;
      lat += wt + 1;
      if (a < nrty) begin ra = 1'b0; re = 1'b0; rr = 1'b1; end
      else begin ra = fa; re = fe; rr = fr; end
      if (re) begin
        err = 1'b1; done = 1;
      end else if (rr) begin
`ifdef APB2WBN_RETRY_EN
        if (a >= int'(RTY_MAX)) begin err = 1'b1; done = 1; end
        else begin lat += 1; a++; end
`else
        err = 1'b1; done = 1;
`endif
      end else if (ra) begin
        prd = we ? 32'h0 : rd; done = 1;
      end else begin
        done = 1;
      end
    end
  endfunction

  // One APB transfer; lat counts cycles from setup (cycle 0) to the pready cycle.
  task automatic apb_xfer(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                          output logic err, output logic rdy_after);
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = we;
    apb_paddr = addr; apb_pstrb = strb; apb_pwdata = wdata;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    lat = 1;
    while (!apb_pready && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = apb_prdata;
    err   = apb_pslverr;
    @(posedge clk); #1;
    apb_psel = 1'b0; apb_penable = 1'b0;
    rdy_after = apb_pready;
  endtask

  task automatic set_slave(input int wt, input int nrty, input logic fa, input logic fe,
                           input logic fr, input logic [31:0] rd);
    cfg_wait = wt; cfg_nrty = nrty; f_ack = fa; f_err = fe; f_rty = fr; cfg_rdata = rd;
  endtask

  // Runs one transfer against the model and compares every observable.
  task automatic run_check(input string tag, input logic we, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] wdata);
    int          lat, exp_lat, exp_nb;
    logic [31:0] rdata, exp_prd;
    logic        err, exp_err, rdy_after;
    logic [3:0]  exp_sel;
    model(we, cfg_wait, cfg_nrty, f_ack, f_err, f_rty, cfg_rdata, exp_lat, exp_nb, exp_err, exp_prd);
    exp_sel = we ? strb : 4'hF;
    clear_mon();
    apb_xfer(we, addr, strb, wdata, lat, rdata, err, rdy_after);
    n_checks += 8;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
    else n_pass++;
    if (err !== exp_err) $display("FAIL %s pslverr: got %b expected %b", tag, err, exp_err);
    else n_pass++;
    if (rdata !== exp_prd) $display("FAIL %s prdata: got %h expected %h", tag, rdata, exp_prd);
    else n_pass++;
    if (adr_seen !== addr || we_seen !== we)
      $display("FAIL %s adr/we: got %h/%b expected %h/%b", tag, adr_seen, we_seen, addr, we);
    else n_pass++;
    if (sel_seen !== exp_sel || dat_seen !== wdata)
      $display("FAIL %s sel/dat_w: got %h/%h expected %h/%h", tag, sel_seen, dat_seen, exp_sel, wdata);
    else n_pass++;
    if (bursts !== exp_nb) $display("FAIL %s stb bursts: got %0d expected %0d", tag, bursts, exp_nb);
    else n_pass++;
    if (changed !== 1'b0) $display("FAIL %s bus stability: got %b expected 0", tag, changed);
    else n_pass++;
    if (pready_cnt !== 1 || rdy_after !== 1'b0)
      $display("FAIL %s pready pulse: got count %0d after %b expected 1 after 0", tag, pready_cnt, rdy_after);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 3;
    if ({wbn_cyc, wbn_stb, wbn_we} !== 3'b000)
      $display("FAIL reset wb ctl: got %b expected 000", {wbn_cyc, wbn_stb, wbn_we});
    else n_pass++;
    if ({wbn_adr, wbn_sel, wbn_dat_w} !== 68'h0)
      $display("FAIL reset wb bus: got %h expected 0", {wbn_adr, wbn_sel, wbn_dat_w});
    else n_pass++;
    if ({apb_prdata, apb_pready, apb_pslverr} !== 34'h0)
      $display("FAIL reset apb: got %h expected 0", {apb_prdata, apb_pready, apb_pslverr});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_write();
    set_slave(0, 0, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001);
    run_check("write_min", 1'b1, 32'h10, 4'h3, 32'hDEAD_BEEF);
  endtask

  task automatic test_read_wait();
    set_slave(3, 0, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
    run_check("read_wait3", 1'b0, 32'h20, 4'h0, 32'h0);
  endtask

  task automatic test_err_ack();
    set_slave(1, 0, 1'b1, 1'b1, 1'b0, 32'hA5A5_A5A5);
    run_check("err_ack", 1'b0, 32'h30, 4'h0, 32'h0);
    set_slave(0, 0, 1'b1, 1'b1, 1'b1, 32'h5A5A_5A5A);
    run_check("err_rty_ack", 1'b1, 32'h34, 4'hC, 32'h0BAD_F00D);
  endtask

  task automatic test_retry();
    set_slave(0, 0, 1'b1, 1'b0, 1'b1, 32'h7777_0000);
    run_check("rty_ack", 1'b0, 32'h40, 4'h0, 32'h0);
`ifdef APB2WBN_RETRY_EN
    set_slave(0, 2, 1'b1, 1'b0, 1'b0, 32'h0000_BEEF);
    run_check("rty2_then_ack", 1'b0, 32'h44, 4'h0, 32'h0);
    set_slave(1, 0, 1'b0, 1'b0, 1'b1, 32'h1);
    run_check("rty_exhaust", 1'b1, 32'h48, 4'h5, 32'h1111_2222);
`else
    set_slave(2, 0, 1'b0, 1'b0, 1'b1, 32'h1);
    run_check("rty_as_err", 1'b0, 32'h44, 4'h0, 32'h0);
`endif
  endtask

  task automatic test_random();
    logic [2:0] fl;
    for (int i = 0; i < 30; i++) begin
      fl = 3'($urandom_range(1, 7));
`ifdef APB2WBN_RETRY_EN
      set_slave(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), fl[0], fl[1], fl[2], $urandom);
`else
      set_slave(int'($urandom_range(0, 3)), 0, fl[0], fl[1], fl[2], $urandom);
`endif
      run_check($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
    end
  endtask

  // psel withdrawn mid-transfer plus a stray setup phase while busy.
  task automatic test_protocol();
    int lat;
    set_slave(4, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    clear_mon();
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b1;
    apb_paddr = 32'h100; apb_pstrb = 4'hF; apb_pwdata = 32'h0102_0304;
    @(posedge clk); #1;
    apb_psel = 1'b0;
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 32'h200; apb_pwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    apb_psel = 1'b0;
    lat = 3;
    while (!apb_pready && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks += 3;
    if (lat !== 6) $display("FAIL proto latency: got %0d expected 6", lat);
    else n_pass++;
    if (adr_seen !== 32'h100 || dat_seen !== 32'h0102_0304 || changed !== 1'b0)
      $display("FAIL proto bus: got %h/%h changed %b expected 100/01020304 changed 0", adr_seen, dat_seen, changed);
    else n_pass++;
    if (bursts !== 1 || pready_cnt !== 1)
      $display("FAIL proto pulses: got bursts %0d pready %0d expected 1 1", bursts, pready_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    set_slave(6, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    clear_mon();
    @(posedge clk); #1;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 32'h300;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (wbn_stb !== 1'b1) $display("FAIL abort precondition stb: got %b expected 1", wbn_stb);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({wbn_cyc, wbn_stb} !== 2'b00) $display("FAIL abort cyc/stb: got %b expected 00", {wbn_cyc, wbn_stb});
    else n_pass++;
    rst = 1'b0; apb_psel = 1'b0; apb_penable = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (pready_cnt !== 0 || bursts !== 1)
      $display("FAIL abort pready: got pready %0d bursts %0d expected 0 1", pready_cnt, bursts);
    else n_pass++;
    set_slave(0, 0, 1'b1, 1'b0, 1'b0, 32'h9876_5432);
    run_check("after_abort", 1'b0, 32'h304, 4'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_err_ack();
    test_retry();
    test_protocol();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
